// File: rtl/acu_issue_sched.sv
// Oldest-first ACU issue scheduler: picks one ready RS entry per cycle, buffers its result
// in a small FIFO and drains it to the CDB. Optional perf counters: ACU_SCHED_PERF_EN.
`timescale 1ns/1ps

module acu_issue_sched #(
    parameter int SIZE   = 15,
    parameter int QDEPTH = 4,
    parameter int SAL_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     alloc,
    input  logic [$clog2(SIZE)-1:0]  alloc_idx,
    input  logic [SIZE-1:0]          ready,
    input  logic [SIZE*SAL_W-1:0]    acu_out,
    output logic [SIZE-1:0]          issue_ack,
    output logic                     cdb_valid,
    output logic [SAL_W-1:0]         cdb_data,
    input  logic                     cdb_ready,
    output logic [31:0]              stall_cnt,
    output logic [31:0]              issue_cnt
);

    localparam int IW = $clog2(SIZE);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [SIZE-1:0]  tracked_reg, tracked_next;
    // age_reg[j][i] = 1 means entry j was allocated before entry i
    logic [SIZE-1:0]  age_reg  [SIZE];
    logic [SIZE-1:0]  age_next [SIZE];
    logic [SIZE-1:0]  elig;
    logic [SIZE-1:0]  win;

    logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [SAL_W-1:0] fifo_mem [QDEPTH];
    logic [SAL_W-1:0] push_data;

    logic alloc_ok;
    logic any_elig;
    logic pop;
    logic space;
    logic do_issue;

    assign alloc_ok = alloc & ~flush & ({1'b0, alloc_idx} < (IW+1)'(SIZE));
    assign elig     = tracked_reg & ready;
    assign any_elig = |elig;

    // An entry wins when no other eligible entry is older than it
    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_win
            logic [SIZE-1:0] older_col;
            for (genvar gj = 0; gj < SIZE; gj++) begin : g_col
                assign older_col[gj] = age_reg[gj][gi];
            end
            assign win[gi] = elig[gi] & ~|(elig & older_col);
        end
    endgenerate

    assign cdb_valid = (count_reg != '0);
    assign pop       = cdb_valid & cdb_ready;
    assign space     = (count_reg < CW'(QDEPTH)) | pop;
    assign do_issue  = any_elig & space & ~flush;
    assign issue_ack = do_issue ? win : '0;

    always_comb begin
        push_data = '0;
        for (int i = 0; i < SIZE; i++) begin
            push_data = push_data | (acu_out[i*SAL_W +: SAL_W] & {SAL_W{win[i]}});
        end
    end

    always_comb begin
        tracked_next = tracked_reg & ~issue_ack;
        if (alloc_ok) begin
            tracked_next[alloc_idx] = 1'b1;
        end
    end

    // A new entry is younger than every entry already tracked
    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            age_next[i] = age_reg[i];
            if (alloc_ok) begin
                if (alloc_idx == IW'(i)) begin
                    age_next[i] = '0;
                end else if (tracked_reg[i]) begin
                    age_next[i][alloc_idx] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tracked_reg <= '0;
            for (int i = 0; i < SIZE; i++) begin
                age_reg[i] <= '0;
            end
        end else if (flush) begin
            tracked_reg <= '0;
            for (int i = 0; i < SIZE; i++) begin
                age_reg[i] <= '0;
            end
        end else begin
            tracked_reg <= tracked_next;
            for (int i = 0; i < SIZE; i++) begin
                age_reg[i] <= age_next[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_issue) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_issue, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage has no reset; the head is masked until something is pushed
    always_ff @(posedge clk) begin
        if (do_issue) begin
            fifo_mem[wr_ptr_reg] <= push_data;
        end
    end

    assign cdb_data = cdb_valid ? fifo_mem[rd_ptr_reg] : '0;

`ifdef ACU_SCHED_PERF_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] issue_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            issue_cnt_reg <= '0;
        end else begin
            if (any_elig & ~space & ~flush & ~&stall_cnt_reg) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (do_issue & ~&issue_cnt_reg) begin
                issue_cnt_reg <= issue_cnt_reg + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign issue_cnt = issue_cnt_reg;
`else
    assign stall_cnt = '0;
    assign issue_cnt = '0;
`endif

    a_alloc_untracked: assert property (@(posedge clk) disable iff (rst)
        alloc_ok |-> !tracked_reg[alloc_idx]);

endmodule

// File: tb/tb_acu_issue_sched.sv
// Directed bench for acu_issue_sched: table of per-cycle vectors plus hand-written
// sequences for FIFO full, wrap, flush and asynchronous reset.
`timescale 1ns/1ps

module tb_acu_issue_sched;

    localparam int SIZE   = 15;
    localparam int QDEPTH = 4;
    localparam int SAL_W  = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic                    alloc;
    logic [3:0]              alloc_idx;
    logic [SIZE-1:0]         ready;
    logic [SIZE*SAL_W-1:0]   acu_out;
    logic [SIZE-1:0]         issue_ack;
    logic                    cdb_valid;
    logic [SAL_W-1:0]        cdb_data;
    logic                    cdb_ready;
    logic [31:0]             stall_cnt;
    logic [31:0]             issue_cnt;

    acu_issue_sched #(.SIZE(SIZE), .QDEPTH(QDEPTH), .SAL_W(SAL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .alloc     (alloc),
        .alloc_idx (alloc_idx),
        .ready     (ready),
        .acu_out   (acu_out),
        .issue_ack (issue_ack),
        .cdb_valid (cdb_valid),
        .cdb_data  (cdb_data),
        .cdb_ready (cdb_ready),
        .stall_cnt (stall_cnt),
        .issue_cnt (issue_cnt)
    );

    always #5 clk = ~clk;

    int n_vec     = 0;
    int n_err     = 0;
    int exp_issue = 0;
    int exp_stall = 0;

    typedef struct {
        logic            a;
        logic [3:0]      idx;
        logic [SIZE-1:0] rdy;
        logic [SIZE-1:0] ack;
        logic            v;
        int              didx;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] d(input int i);
        return 32'h5A00_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    function automatic vec_t mk(input logic a, input logic [3:0] idx, input logic [SIZE-1:0] rdy,
                                input logic [SIZE-1:0] ack, input logic v, input int didx);
        vec_t r;
        r.a = a; r.idx = idx; r.rdy = rdy; r.ack = ack; r.v = v; r.didx = didx;
        return r;
    endfunction

    task automatic cyc(input logic a, input logic [3:0] idx, input logic [SIZE-1:0] rdy,
                       input logic cr, input logic fl);
        @(negedge clk);
        alloc     = a;
        alloc_idx = idx;
        ready     = rdy;
        cdb_ready = cr;
        flush     = fl;
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [SIZE-1:0] ack, input logic v, input int didx);
        chk($sformatf("%s.ack", nm), 32'(issue_ack), 32'(ack));
        if (ack != '0) exp_issue++;
        chk($sformatf("%s.valid", nm), 32'(cdb_valid), 32'(v));
        if (didx >= 0) chk($sformatf("%s.data", nm), cdb_data, d(didx));
    endtask

    task automatic chk_perf(input string nm);
`ifdef ACU_SCHED_PERF_EN
        chk($sformatf("%s.stall_cnt", nm), stall_cnt, 32'(exp_stall));
        chk($sformatf("%s.issue_cnt", nm), issue_cnt, 32'(exp_issue));
`else
        chk($sformatf("%s.stall_cnt", nm), stall_cnt, 32'd0);
        chk($sformatf("%s.issue_cnt", nm), issue_cnt, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; alloc = 1'b0; alloc_idx = '0;
        ready = '0; cdb_ready = 1'b0;
        for (int i = 0; i < SIZE; i++) acu_out[i*SAL_W +: SAL_W] = d(i);

        // Table: oldest-first order, same-cycle alloc+ready latency, reverse index order
        tbl.push_back(mk(0, 0, 15'h0000, 15'h0000, 0, -1));
        tbl.push_back(mk(1, 3, 15'h0000, 15'h0000, 0, -1));
        tbl.push_back(mk(1, 7, 15'h0000, 15'h0000, 0, -1));
        tbl.push_back(mk(1, 1, 15'h0000, 15'h0000, 0, -1));
        tbl.push_back(mk(0, 0, 15'h008A, 15'h0008, 0, -1));
        tbl.push_back(mk(0, 0, 15'h008A, 15'h0080, 1,  3));
        tbl.push_back(mk(0, 0, 15'h008A, 15'h0002, 1,  7));
        tbl.push_back(mk(0, 0, 15'h0000, 15'h0000, 1,  1));
        tbl.push_back(mk(0, 0, 15'h0000, 15'h0000, 0, -1));
        tbl.push_back(mk(1, 5, 15'h0020, 15'h0000, 0, -1));
        tbl.push_back(mk(0, 0, 15'h0020, 15'h0020, 0, -1));
        tbl.push_back(mk(0, 0, 15'h0000, 15'h0000, 1,  5));
        tbl.push_back(mk(0, 0, 15'h0000, 15'h0000, 0, -1));
        tbl.push_back(mk(1, 9, 15'h0000, 15'h0000, 0, -1));
        tbl.push_back(mk(1, 2, 15'h0000, 15'h0000, 0, -1));
        tbl.push_back(mk(0, 0, 15'h0204, 15'h0200, 0, -1));
        tbl.push_back(mk(0, 0, 15'h0204, 15'h0004, 1,  9));
        tbl.push_back(mk(0, 0, 15'h0000, 15'h0000, 1,  2));
        tbl.push_back(mk(0, 0, 15'h0000, 15'h0000, 0, -1));

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset.valid", 32'(cdb_valid), 32'd0);
        chk("reset.data", cdb_data, 32'd0);
        chk("reset.ack", 32'(issue_ack), 32'd0);
        chk_perf("reset");
        rst = 1'b0;

        foreach (tbl[i]) begin
            cyc(tbl[i].a, tbl[i].idx, tbl[i].rdy, 1'b1, 1'b0);
            chk_out($sformatf("tbl%0d", i), tbl[i].ack, tbl[i].v, tbl[i].didx);
        end

        // FIFO full: no issue and stall, then pop and issue in the same cycle
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 4'(i), '0, 1'b0, 1'b0);
            chk_out($sformatf("full_alloc%0d", i), '0, 0, -1);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 4'd0, 15'h001F, 1'b0, 1'b0);
            chk_out($sformatf("full_fill%0d", k), 15'(1 << k), (k > 0), (k > 0) ? 0 : -1);
        end
        for (int k = 0; k < 2; k++) begin
            cyc(1'b0, 4'd0, 15'h001F, 1'b0, 1'b0);
            chk_out($sformatf("full_stall%0d", k), '0, 1, 0);
            exp_stall++;
        end
        cyc(1'b0, 4'd0, 15'h001F, 1'b1, 1'b0);
        chk_out("full_popissue", 15'h0010, 1, 0);
        for (int k = 1; k < 5; k++) begin
            cyc(1'b0, 4'd0, '0, 1'b1, 1'b0);
            chk_out($sformatf("full_drain%0d", k), '0, 1, k);
        end
        cyc(1'b0, 4'd0, '0, 1'b1, 1'b0);
        chk_out("full_empty", '0, 0, -1);
        chk_perf("full");

        // Steady full FIFO with push and pop every cycle, pointers wrap
        for (int i = 0; i < 14; i++) begin
            cyc(1'b1, 4'(i), '0, 1'b0, 1'b0);
            chk_out($sformatf("wrap_alloc%0d", i), '0, 0, -1);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 4'd0, 15'h3FFF, 1'b0, 1'b0);
            chk_out($sformatf("wrap_fill%0d", k), 15'(1 << k), (k > 0), (k > 0) ? 0 : -1);
        end
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 4'd0, 15'h3FFF, 1'b1, 1'b0);
            chk_out($sformatf("wrap_steady%0d", k), 15'(1 << (4 + k)), 1, k);
        end
        for (int k = 10; k < 14; k++) begin
            cyc(1'b0, 4'd0, '0, 1'b1, 1'b0);
            chk_out($sformatf("wrap_drain%0d", k), '0, 1, k);
        end
        cyc(1'b0, 4'd0, '0, 1'b1, 1'b0);
        chk_out("wrap_empty", '0, 0, -1);
        chk_perf("wrap");

        // Flush with two buffered results and three ready entries
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 4'(i), '0, 1'b0, 1'b0);
            chk_out($sformatf("fl_alloc%0d", i), '0, 0, -1);
        end
        cyc(1'b0, 4'd0, 15'h0003, 1'b0, 1'b0);
        chk_out("fl_issue0", 15'h0001, 0, -1);
        cyc(1'b0, 4'd0, 15'h0003, 1'b0, 1'b0);
        chk_out("fl_issue1", 15'h0002, 1, 0);
        cyc(1'b1, 4'd6, 15'h001C, 1'b1, 1'b1);
        chk_out("fl_flush", '0, 1, 0);
        cyc(1'b0, 4'd0, 15'h005C, 1'b1, 1'b0);
        chk_out("fl_after", '0, 0, -1);
        chk_perf("fl_after");
        cyc(1'b1, 4'd2, 15'h005C, 1'b1, 1'b0);
        chk_out("fl_realloc", '0, 0, -1);
        cyc(1'b0, 4'd0, 15'h005C, 1'b1, 1'b0);
        chk_out("fl_reissue", 15'h0004, 0, -1);
        cyc(1'b0, 4'd0, '0, 1'b1, 1'b0);
        chk_out("fl_result", '0, 1, 2);
        cyc(1'b0, 4'd0, '0, 1'b1, 1'b0);
        chk_out("fl_empty", '0, 0, -1);

        // Asynchronous reset between edges while results are buffered
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 4'(i), '0, 1'b0, 1'b0);
            chk_out($sformatf("ar_alloc%0d", i), '0, 0, -1);
        end
        cyc(1'b0, 4'd0, 15'h0003, 1'b0, 1'b0);
        chk_out("ar_issue0", 15'h0001, 0, -1);
        cyc(1'b0, 4'd0, 15'h0003, 1'b0, 1'b0);
        chk_out("ar_issue1", 15'h0002, 1, 0);
        cyc(1'b0, 4'd0, '0, 1'b0, 1'b0);
        chk_out("ar_hold", '0, 1, 0);
        #2;
        rst   = 1'b1;
        ready = 15'h0004;
        #1;
        exp_issue = 0;
        exp_stall = 0;
        chk("ar_now.valid", 32'(cdb_valid), 32'd0);
        chk("ar_now.data", cdb_data, 32'd0);
        chk("ar_now.ack", 32'(issue_ack), 32'd0);
        chk_perf("ar_now");
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 4'd0, 15'h0004, 1'b1, 1'b0);
        chk_out("ar_gone", '0, 0, -1);
        cyc(1'b1, 4'd8, '0, 1'b1, 1'b0);
        chk_out("ar_alloc8", '0, 0, -1);
        cyc(1'b0, 4'd0, 15'h0100, 1'b1, 1'b0);
        chk_out("ar_issue8", 15'h0100, 0, -1);
        cyc(1'b0, 4'd0, '0, 1'b1, 1'b0);
        chk_out("ar_result", '0, 1, 8);
        chk_perf("ar_result");
        cyc(1'b0, 4'd0, '0, 1'b1, 1'b0);
        chk_out("ar_empty", '0, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
